snap_bram_playback_reader: RTL and testbench

- Fabric-side reader for a processor-loaded snapshot BRAM: streams port-A words (64b x 512) out as a valid/ready stream, single-shot or looping.
- Sits between the bram_block_custom port A (we tied low) and downstream DSP/DAC test logic; the processor fills the RAM via port B beforehand.
- Handles registered BRAM read latency with a credit-controlled skid FIFO so downstream backpressure never loses data.

---
 rtl/snap_playback_pkg.sv | 28 ++
 rtl/snap_playback_skid_fifo.sv | 81 ++++++++
 rtl/snap_bram_playback_reader.sv | 204 ++++++++++++++++++++
 tb/tb_snap_bram_playback_reader.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snap_playback_pkg.sv
// ============================================================================
// Module  : snap_playback_pkg
// Brief   : Shared types and width helpers for the snapshot BRAM playback reader.
// Revision: 1.0
// ============================================================================
`default_nettype none

package snap_playback_pkg;

  localparam int DEF_DWIDTH     = 64;
  localparam int DEF_AWIDTH     = 9;
  localparam int DEF_RD_LATENCY = 3;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Bits needed to hold a count in the range 0..n inclusive.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/snap_playback_skid_fifo.sv
// ============================================================================
// Module  : snap_playback_skid_fifo
// Brief   : Register-based first-word-fall-through FIFO absorbing BRAM read data.
// Revision: 1.0
// ============================================================================
`default_nettype none

module snap_playback_skid_fifo
  import snap_playback_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH,
  parameter int WIDTH = DEF_DWIDTH,
  localparam int CW   = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q != CW'(DEPTH)) || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = next_ptr(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/snap_bram_playback_reader.sv
// ============================================================================
// Module  : snap_bram_playback_reader
// Brief   : Streams snapshot BRAM port-A words as valid/ready, single-shot or
//           looping. Define PLAYBACK_PASS_CNT_EN to add the pass_count output.
// Revision: 1.0
// ============================================================================
`default_nettype none

module snap_bram_playback_reader
  import snap_playback_pkg::*;
#(
  parameter int DWIDTH     = DEF_DWIDTH,
  parameter int AWIDTH     = DEF_AWIDTH,
  parameter int RD_LATENCY = DEF_RD_LATENCY,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [AWIDTH:0]   length,
  output logic              bram_en_a,
  output logic              bram_we,
  output logic [AWIDTH-1:0] bram_addr,
  input  logic [DWIDTH-1:0] bram_rd_data,
  output logic [DWIDTH-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              busy,
  output logic              done
`ifdef PLAYBACK_PASS_CNT_EN
  ,
  output logic [31:0]       pass_count
`endif
);

  localparam int FCW = cnt_width(FIFO_DEPTH);
  localparam int OCW = cnt_width(RD_LATENCY);
  localparam int SCW = cnt_width(FIFO_DEPTH + RD_LATENCY);
  localparam logic [AWIDTH:0] FULL_LEN = {1'b1, {AWIDTH{1'b0}}};

  generate
    if (FIFO_DEPTH < RD_LATENCY + 1) begin : g_depth_check
      $error("FIFO_DEPTH must be at least RD_LATENCY+1");
    end
  endgenerate

  state_e                state_q, state_d;
  logic [AWIDTH-1:0]     addr_q, addr_d;
  logic [AWIDTH:0]       len_q, len_d;
  logic                  loop_q, loop_d;
  logic [RD_LATENCY-1:0] vld_pipe_q, vld_pipe_d;
  logic                  done_q, done_d;

  logic                  issue, last_word, credit_ok;
  logic [OCW-1:0]        outstanding;
  logic [FCW-1:0]        fifo_count;
  logic [DWIDTH-1:0]     fifo_dout;
  logic                  fifo_empty, fifo_push, fifo_pop, tail_vld, pop_out;

  always_comb begin
    outstanding = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      outstanding = outstanding + OCW'(vld_pipe_q[i]);
    end
  end

  // Every in-flight read already owns a FIFO slot, so the FIFO can never overflow.
  assign credit_ok = (SCW'(outstanding) + SCW'(fifo_count)) < SCW'(FIFO_DEPTH);
  assign last_word = ({1'b0, addr_q} == (len_q - (AWIDTH + 1)'(1)));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    loop_d  = loop_q;
    done_d  = 1'b0;
    issue   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d   = ((length == '0) || (length > FULL_LEN)) ? FULL_LEN : length;
          loop_d  = loop_en;
          addr_d  = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_DRAIN;
        end else if (credit_ok) begin
          issue = 1'b1;
          if (last_word) begin
            addr_d = '0;
            if (!loop_q) begin
              state_d = ST_DRAIN;
            end
          end else begin
            addr_d = addr_q + AWIDTH'(1);
          end
        end
      end
      ST_DRAIN: begin
        if ((outstanding == '0) && fifo_empty) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    vld_pipe_d    = vld_pipe_q << 1;
    vld_pipe_d[0] = issue;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      loop_q     <= 1'b0;
      vld_pipe_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      loop_q     <= loop_d;
      vld_pipe_q <= vld_pipe_d;
      done_q     <= done_d;
    end
  end

  // Arriving data bypasses an empty FIFO so the first word is visible on arrival.
  assign tail_vld   = vld_pipe_q[RD_LATENCY-1];
  assign fifo_empty = (fifo_count == '0);
  assign dout_valid = tail_vld | ~fifo_empty;
  assign pop_out    = dout_valid & dout_ready;
  assign fifo_pop   = pop_out & ~fifo_empty;
  assign fifo_push  = tail_vld & ~(fifo_empty & dout_ready);
  assign dout       = dout_valid ? (fifo_empty ? bram_rd_data : fifo_dout) : '0;

  snap_playback_skid_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DWIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (bram_rd_data),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .count (fifo_count)
  );

  assign bram_en_a = issue;
  assign bram_we   = 1'b0;
  assign bram_addr = addr_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;

`ifdef PLAYBACK_PASS_CNT_EN
  logic [AWIDTH:0] out_idx_q, out_idx_d;
  logic [31:0]     pass_cnt_q, pass_cnt_d;

  always_comb begin
    out_idx_d  = out_idx_q;
    pass_cnt_d = pass_cnt_q;
    if ((state_q == ST_IDLE) && start) begin
      out_idx_d  = '0;
      pass_cnt_d = '0;
    end else if (pop_out) begin
      if (out_idx_q == (len_q - (AWIDTH + 1)'(1))) begin
        out_idx_d = '0;
        if (pass_cnt_q != '1) begin
          pass_cnt_d = pass_cnt_q + 32'd1;
        end
      end else begin
        out_idx_d = out_idx_q + (AWIDTH + 1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_idx_q  <= '0;
      pass_cnt_q <= '0;
    end else begin
      out_idx_q  <= out_idx_d;
      pass_cnt_q <= pass_cnt_d;
    end
  end

  assign pass_count = pass_cnt_q;
`else
  // Build without the pass counter: no extra state.
`endif

endmodule

`default_nettype wire

// File: tb/tb_snap_bram_playback_reader.sv
// ============================================================================
// Module  : tb_snap_bram_playback_reader
// Brief   : Self-checking bench: BRAM model, issue/queue reference model, and
//           directed plus randomized backpressure scenarios.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_snap_bram_playback_reader;

  localparam int DW    = 64;
  localparam int AW    = 9;
  localparam int LAT   = 3;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          loop_en = 1'b0;
  logic [AW:0]   length = '0;
  logic          bram_en_a, bram_we;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_rd_data;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready = 1'b1;
  logic          busy, done;
`ifdef PLAYBACK_PASS_CNT_EN
  logic [31:0]   pass_count;
`endif

  snap_bram_playback_reader #(
    .DWIDTH     (DW),
    .AWIDTH     (AW),
    .RD_LATENCY (LAT),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stop         (stop),
    .loop_en      (loop_en),
    .length       (length),
    .bram_en_a    (bram_en_a),
    .bram_we      (bram_we),
    .bram_addr    (bram_addr),
    .bram_rd_data (bram_rd_data),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .dout_ready   (dout_ready),
    .busy         (busy),
    .done         (done)
`ifdef PLAYBACK_PASS_CNT_EN
    ,
    .pass_count   (pass_count)
`endif
  );

  always #5 clk = ~clk;

  // BRAM port A model: three register stages, garbage when not enabled.
  logic [DW-1:0] mem [1 << AW];
  logic [DW-1:0] rd_p0, rd_p1, rd_p2;
  always @(posedge clk) begin
    rd_p0 <= bram_en_a ? mem[bram_addr] : {$urandom, $urandom};
    rd_p1 <= rd_p0;
    rd_p2 <= rd_p1;
  end
  assign bram_rd_data = rd_p2;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model state.
  int            cyc = 0;
  int            len_m = 1;
  int            issued = 0;
  int            popped = 0;
  int            done_cnt = 0;
  int            valid_cnt = 0;
  int            full_seen = 0;
  int            start_cyc = 0;
  int            first_valid_cyc = -1;
  int            first_pop_cyc = -1;
  int            last_pop_cyc = -1;
  bit            stop_chk = 0;
  logic [DW-1:0] expq [$];

  int ready_mode = 0;
  int ready_hold = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (ready_hold > 0) begin
      dout_ready = 1'b0;
      ready_hold--;
    end else if (ready_mode == 1) begin
      dout_ready = ($urandom_range(1, 0) == 1);
    end else begin
      dout_ready = 1'b1;
    end
  end

  always @(negedge clk) begin
    int held;
    if (!rst) begin
      held = issued - popped;
      if (dout_valid) begin
        valid_cnt++;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
      end
      if (done) done_cnt++;
      if (stop_chk) check_eq("no_read_after_stop", bram_en_a, 1'b0);
      if (dout_valid && dout_ready) begin
        if (expq.size() == 0) begin
          check_eq("unexpected_pop", dout_valid, 1'b0);
        end else begin
          check_eq("dout", dout, expq.pop_front());
        end
        popped++;
        if (first_pop_cyc < 0) first_pop_cyc = cyc;
        last_pop_cyc = cyc;
      end
      if (held >= DEPTH) full_seen++;
      if (bram_en_a) begin
        check_eq("credit", (held < DEPTH), 1'b1);
        check_eq("addr", bram_addr, (issued % len_m));
        check_eq("we", bram_we, 1'b0);
        expq.push_back(mem[issued % len_m]);
        issued++;
      end
    end
  end

  task automatic clear_model();
    issued          = 0;
    popped          = 0;
    done_cnt        = 0;
    valid_cnt       = 0;
    full_seen       = 0;
    first_valid_cyc = -1;
    first_pop_cyc   = -1;
    last_pop_cyc    = -1;
    expq.delete();
  endtask

  task automatic run_start(input int len, input bit lp);
    @(posedge clk);
    #1;
    clear_model();
    len_m     = (len == 0 || len > (1 << AW)) ? (1 << AW) : len;
    start_cyc = cyc;
    start     = 1'b1;
    loop_en   = lp;
    length    = (AW + 1)'(len);
    @(posedge clk);
    #1;
    start     = 1'b0;
  endtask

  task automatic wait_pops(input int n, input int budget);
    int i = 0;
    while (popped < n && i < budget) begin
      @(negedge clk);
      #1;
      i++;
    end
    check_eq("pop_timeout", (popped >= n), 1'b1);
  endtask

  task automatic wait_idle(input int budget);
    int i = 0;
    @(negedge clk);
    while (busy && i < budget) begin
      @(negedge clk);
      i++;
    end
    check_eq("idle_timeout", busy, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    check_eq("done_pulses", done_cnt, 1);
    check_eq("queue_drained", expq.size(), 0);
  endtask

  task automatic pulse_stop();
    @(posedge clk);
    #1;
    stop     = 1'b1;
    stop_chk = 1'b1;
    @(posedge clk);
    #1;
    stop     = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_valid", dout_valid, 1'b0);
    check_eq("rst_en", bram_en_a, 1'b0);
    check_eq("rst_dout", dout, 64'd0);
    check_eq("rst_addr", bram_addr, 0);

    // stop while idle is ignored
    @(posedge clk);
    #1;
    stop = 1'b1;
    @(posedge clk);
    #1;
    stop = 1'b0;
    @(negedge clk);
    check_eq("idle_stop_busy", busy, 1'b0);

    // Single shot, length 8, ready high
    run_start(8, 0);
    wait_idle(100);
    check_eq("t1_pops", popped, 8);
    check_eq("t1_first_valid", first_valid_cyc - start_cyc, 4);
    check_eq("t1_back_to_back", last_pop_cyc - first_pop_cyc, 7);

    // length 0 means the full RAM
    run_start(0, 0);
    wait_idle(1000);
    check_eq("t2_pops", popped, 512);
    check_eq("t2_back_to_back", last_pop_cyc - first_pop_cyc, 511);

    // Loop length 3, stop after 10 pops; start and stop together in idle
    @(posedge clk);
    #1;
    stop = 1'b1;
    run_start(3, 1);
    stop = 1'b0;
    wait_pops(10, 100);
    pulse_stop();
    wait_idle(100);
    stop_chk = 1'b0;
    check_eq("t3_min_pops", (popped >= 10), 1'b1);
    check_eq("t3_pops_eq_issued", popped, issued);

    // length 16, random backpressure with an initial stall burst
    for (int i = 0; i < (1 << AW); i++) mem[i] = {$urandom, $urandom};
    ready_hold = 8;
    ready_mode = 1;
    run_start(16, 0);
    wait_idle(400);
    ready_mode = 0;
    check_eq("t4_pops", popped, 16);
    check_eq("t4_credit_stall", (full_seen > 0), 1'b1);

    // start while busy is ignored
    run_start(6, 0);
    @(posedge clk);
    #1;
    start  = 1'b1;
    length = (AW + 1)'(2);
    @(posedge clk);
    #1;
    start  = 1'b0;
    wait_idle(100);
    check_eq("t5_pops", popped, 6);

    // Reset in the middle of a run with reads in flight
    run_start(16, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_model();
    @(negedge clk);
    check_eq("mr_valid", dout_valid, 1'b0);
    check_eq("mr_dout", dout, 64'd0);
    check_eq("mr_en", bram_en_a, 1'b0);
    check_eq("mr_busy", busy, 1'b0);
    check_eq("mr_done", done, 1'b0);
    check_eq("mr_addr", bram_addr, 0);
    repeat (10) @(negedge clk);
    #1;
    check_eq("mr_no_stale_valid", valid_cnt, 0);
    check_eq("mr_no_done", done_cnt, 0);
    run_start(4, 0);
    wait_idle(100);
    check_eq("mr_replay_pops", popped, 4);

`ifdef PLAYBACK_PASS_CNT_EN
    run_start(4, 1);
    wait_pops(12, 200);
    @(negedge clk);
    check_eq("pass_count_3", pass_count, 32'd3);
    pulse_stop();
    wait_idle(100);
    stop_chk = 1'b0;
    run_start(2, 0);
    @(negedge clk);
    check_eq("pass_count_clear", pass_count, 32'd0);
    wait_idle(100);
    check_eq("pass_count_single", pass_count, 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
